// File: rtl/servo_io_pkg.sv
// Shared constants and helpers for the servo I/O conditioning blocks.
package servo_io_pkg;

  // A synchroniser shorter than this gives no metastability protection.
  localparam int MIN_SYNC_STAGES = 32'sd2;

  // 1 ms of debounce at a 50 MHz system clock.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 32'sd50000;

  // Ceiling log2 for sizing counters at elaboration time.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 32'sd0;
    remaining = value - 32'sd1;
    while (remaining > 32'sd0) begin
      result    = result + 32'sd1;
      remaining = remaining >>> 32'sd1;
    end
    return result;
  endfunction

  // Counter width able to hold 0 .. cycles-1, never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = clog2(cycles);
    if (w < 32'sd1) begin
      w = 32'sd1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Parametrised multi-bit flip-flop synchroniser; pure shift chain, no logic
// between stages so every bit gets the full settling time of each stage.
module sync_chain
  import servo_io_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = MIN_SYNC_STAGES,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Depth is clamped so a mis-set parameter cannot drop below a safe chain.
  localparam int DEPTH = (STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : STAGES;

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift the raw inputs through the chain; reset loads every stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: synchronise raw pins, debounce each channel
// with a tick-scaled counter, and emit registered one-cycle rise/fall pulses.
module input_conditioner
  import servo_io_pkg::*;
#(
  parameter int                  CHANNELS        = 4,
  parameter int                  SYNC_STAGES     = 2,
  parameter int                  DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [CHANNELS-1:0] RESET_VALUE     = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                changed
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  // Count value at which one more qualifying tick accepts the new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CHANNELS-1:0] sync_s;

  sync_chain #(
    .WIDTH       (CHANNELS),
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (sync_s)
  );

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;

    // Debounce decision: any agreeing cycle restarts the count, a full run
    // of disagreeing ticks adopts the synchronised value and fires a pulse.
    always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sync_s[ch] == level_q) begin
        cnt_d = '0;
      end else if (!tick) begin
        cnt_d = cnt_q;
      end else if (cnt_q == CNT_LAST) begin
        level_d = sync_s[ch];
        cnt_d   = '0;
        rise_d  = sync_s[ch];
        fall_d  = ~sync_s[ch];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Channel state; a reset mid-count discards the partial count.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q   <= '0;
        level_q <= RESET_VALUE[ch];
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        level_q <= level_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    assign level[ch] = level_q;
    assign rise[ch]  = rise_q;
    assign fall[ch]  = fall_q;
  end

  assign changed = |(rise | fall);

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios followed by
// random stimulus, all compared against a behavioural model every cycle.
module tb_input_conditioner;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic [CH-1:0] din;
  logic [CH-1:0] level;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic          changed;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: din samples in flight through the synchroniser, the accepted
  // level, and how many qualifying ticks the synchronised input has disagreed.
  logic [CH-1:0] m_pipe [SS];
  int            m_run  [CH];
  logic [CH-1:0] m_level;
  logic [CH-1:0] m_rise;
  logic [CH-1:0] m_fall;

  input_conditioner #(
    .CHANNELS        (CH),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DB),
    .RESET_VALUE     (4'b0000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .din     (din),
    .level   (level),
    .rise    (rise),
    .fall    (fall),
    .changed (changed)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < SS; k++) m_pipe[k] = 4'b0000;
    for (int c = 0; c < CH; c++) m_run[c] = 0;
    m_level = 4'b0000;
    m_rise  = 4'b0000;
    m_fall  = 4'b0000;
  endtask

  // One clock edge of the model: a channel adopts its synchronised value once
  // that value has disagreed with the level for DB consecutive ticks.
  task automatic model_edge();
    logic [CH-1:0] seen;
    seen   = m_pipe[SS-1];
    m_rise = 4'b0000;
    m_fall = 4'b0000;
    for (int c = 0; c < CH; c++) begin
      if (seen[c] === m_level[c]) begin
        m_run[c] = 0;
      end else if (tick) begin
        m_run[c] = m_run[c] + 1;
        if (m_run[c] == DB) begin
          m_level[c] = seen[c];
          m_rise[c]  = seen[c];
          m_fall[c]  = ~seen[c];
          m_run[c]   = 0;
        end
      end
    end
    for (int k = SS - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = din;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_level"}, level, m_level);
    check({tag, "_rise"}, rise, m_rise);
    check({tag, "_fall"}, fall, m_fall);
    check({tag, "_changed"}, {3'b000, changed}, {3'b000, |(m_rise | m_fall)});
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    if (!rst) model_reset();
    else      model_edge();
    #1;
    check_model(tag);
  endtask

  initial begin
    int idx;

    // Scenario 1: reset held with all inputs high, then release.
    model_reset();
    rst  = 1'b0;
    tick = 1'b1;
    din  = 4'b1111;
    #1;
    check("rst_async_level", level, 4'b0000);
    repeat (5) cycle("rst_hold");
    check("rst_level", level, 4'b0000);
    check("rst_changed", {3'b000, changed}, 4'b0000);
    rst = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cycle("rst_release");
      if (k <= 5) check("rel_hold_level", level, 4'b0000);
      if (k == 6) begin
        check("rel_edge6_level", level, 4'b1111);
        check("rel_edge6_rise", rise, 4'b1111);
      end
      if (k == 7) check("rel_edge7_rise", rise, 4'b0000);
    end

    // Scenario 2: clean steps on channel 0 from an all-low level.
    din = 4'b0000;
    for (int k = 1; k <= 7; k++) begin
      cycle("all_low");
      if (k == 6) check("all_low_fall", fall, 4'b1111);
    end
    din = 4'b0001;
    for (int k = 1; k <= 7; k++) begin
      cycle("step_up");
      if (k == 5) check("step_up_edge5_level", level, 4'b0000);
      if (k == 6) begin
        check("step_up_edge6_level", level, 4'b0001);
        check("step_up_edge6_rise", rise, 4'b0001);
      end
      if (k == 7) check("step_up_edge7_rise", rise, 4'b0000);
    end
    din = 4'b0000;
    for (int k = 1; k <= 7; k++) begin
      cycle("step_down");
      if (k == 6) check("step_down_fall", fall, 4'b0001);
      if (k == 7) check("step_down_fall_end", fall, 4'b0000);
    end

    // Scenario 3: bounce on channel 1, high 3 / low 1 / high thereafter.
    din = 4'b0010;
    repeat (3) cycle("bounce_hi");
    din = 4'b0000;
    cycle("bounce_lo");
    din = 4'b0010;
    for (int k = 1; k <= 8; k++) begin
      cycle("bounce_final");
      if (k < 6) check("bounce_no_change", level, 4'b0000);
      if (k == 6) begin
        check("bounce_level", level, 4'b0010);
        check("bounce_rise", rise, 4'b0010);
      end
    end

    // Scenario 4: tick qualifies only one edge in three.
    din = 4'b0110;
    for (int k = 1; k <= 14; k++) begin
      tick = (k % 3 == 0);
      cycle("tick_gate");
      if (k == 11) check("tick_edge11_level", level, 4'b0010);
      if (k == 12) begin
        check("tick_edge12_level", level, 4'b0110);
        check("tick_edge12_rise", rise, 4'b0100);
      end
    end
    tick = 1'b1;

    // Scenario 5: simultaneous steps, then one channel alone.
    din = 4'b0000;
    repeat (7) cycle("indep_clear");
    din = 4'b0101;
    for (int k = 1; k <= 7; k++) begin
      cycle("indep_up");
      if (k == 6) begin
        check("indep_rise", rise, 4'b0101);
        check("indep_fall", fall, 4'b0000);
        check("indep_changed", {3'b000, changed}, 4'b0001);
      end
      if (k == 7) check("indep_changed_end", {3'b000, changed}, 4'b0000);
    end
    din = 4'b0100;
    for (int k = 1; k <= 7; k++) begin
      cycle("indep_down");
      if (k == 6) begin
        check("indep_fall_ch0", fall, 4'b0001);
        check("indep_rise_none", rise, 4'b0000);
      end
    end

    // Scenario 6: reset taken after channel 3 has counted to 2.
    din = 4'b1100;
    repeat (4) cycle("midcount");
    rst = 1'b0;
    #1;
    model_reset();
    check("midcount_async_level", level, 4'b0000);
    cycle("midcount_rst");
    rst = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cycle("midcount_release");
      if (k == 5) check("midcount_edge5_level", level, 4'b0000);
      if (k == 6) begin
        check("midcount_edge6_level", level, 4'b1100);
        check("midcount_edge6_rise", rise, 4'b1100);
      end
    end

    // Random phase: sparse toggles, irregular ticks, occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, CH - 1);
        din[idx] = ~din[idx];
      end
      tick = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0;
        #1;
        model_reset();
        check_model("rand_async_rst");
        cycle("rand_rst");
        rst = 1'b1;
      end else begin
        cycle("rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
